// File: rtl/oai221_sweep_checker.sv
// oai221_sweep_checker: sweeps all 32 OAI221 input vectors and checks sampled ZN against a truth table
module oai221_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter logic [31:0] EXPECT = 32'h111F_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  dut_in,
  input  logic        zn,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic        first_fail_vld,
  output logic [4:0]  first_fail_idx,
  output logic [31:0] resp_vec
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);
  state_t state;
  logic [7:0] cnt;
  logic miss;
  logic [5:0] err_next;
  assign miss = zn != EXPECT[dut_in];
  assign err_next = err_count + {5'd0, miss};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      dut_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      resp_vec <= '0;
    end else if (state != RUN) begin
      if (start) begin
        state <= RUN;
        cnt <= RELOAD;
        dut_in <= '0;
        busy <= 1'b1;
        done <= 1'b0;
        pass <= 1'b0;
        err_count <= '0;
        first_fail_vld <= 1'b0;
        first_fail_idx <= '0;
        resp_vec <= '0;
      end
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end else begin
      // last edge of the settle window: sample, score, then advance or finish
      resp_vec[dut_in] <= zn;
      err_count <= err_next;
      if (miss && !first_fail_vld) begin
        first_fail_vld <= 1'b1;
        first_fail_idx <= dut_in;
      end
      if (dut_in != 5'd31) begin
        dut_in <= dut_in + 5'd1;
        cnt <= RELOAD;
      end else begin
        state <= DONE;
        dut_in <= '0;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= err_next == 6'd0;
      end
    end
  end
endmodule

// File: tb/tb_oai221_sweep_checker.sv
// tb_oai221_sweep_checker: cycle model of the sweep for two instances (settle 2 and settle 1)
module tb_oai221_sweep_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st [2];
  int mode [2];
  logic zn [2];
  logic [4:0] di [2];
  logic busy [2], done [2], pass_o [2], ffv [2];
  logic [5:0] err [2];
  logic [4:0] ffi [2];
  logic [31:0] resp [2];
  int total = 0, bad = 0;
  bit armed = 0;
  bit act [2];
  int k [2], ml [2];

  always #5 clk = ~clk;

  function automatic logic oai(input int j);
    logic [4:0] v;
    v = 5'(j);
    return !(v[4] & (v[3] | v[2]) & (v[1] | v[0]));
  endfunction

  // mode 0: good cell, 1: ZN stuck at 1, 2: inverted cell
  function automatic logic zref(input int m, input int j);
    return m == 0 ? oai(j) : m == 1 ? 1'b1 : !oai(j);
  endfunction

  assign zn[0] = zref(mode[0], int'(di[0]));
  assign zn[1] = zref(mode[1], int'(di[1]));

  oai221_sweep_checker #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .dut_in(di[0]), .zn(zn[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass_o[0]), .err_count(err[0]),
    .first_fail_vld(ffv[0]), .first_fail_idx(ffi[0]), .resp_vec(resp[0]));

  oai221_sweep_checker #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .dut_in(di[1]), .zn(zn[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass_o[1]), .err_count(err[1]),
    .first_fail_vld(ffv[1]), .first_fail_idx(ffi[1]), .resp_vec(resp[1]));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // model: k counts cycles since the accepted start edge
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        armed = 1;
        act[d] = 0;
        k[d] = 0;
      end else if (st[d] && (!act[d] || k[d] >= 32 * (d == 0 ? 2 : 1))) begin
        act[d] = 1;
        k[d] = 0;
        ml[d] = mode[d];
      end else if (act[d] && k[d] < 32 * (d == 0 ? 2 : 1)) begin
        k[d]++;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        int s, n, ee, fi, cur;
        bit fv, run, dn;
        logic [31:0] er;
        logic z;
        s = d == 0 ? 2 : 1;
        n = !act[d] ? 0 : (k[d] / s > 32 ? 32 : k[d] / s);
        er = '0; ee = 0; fv = 0; fi = 0;
        for (int j = 0; j < n; j++) begin
          z = zref(ml[d], j);
          er[j] = z;
          if (z != oai(j)) begin
            ee++;
            if (!fv) begin fv = 1; fi = j; end
          end
        end
        run = act[d] && k[d] < 32 * s;
        dn = act[d] && !run;
        cur = run ? k[d] / s : 0;
        chk($sformatf("dut_in[%0d]", d), 32'(di[d]), cur);
        chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(run));
        chk($sformatf("done[%0d]", d), 32'(done[d]), 32'(dn));
        if (dn || !act[d]) chk($sformatf("pass[%0d]", d), 32'(pass_o[d]), 32'(dn && ee == 0));
        chk($sformatf("err_count[%0d]", d), 32'(err[d]), ee);
        chk($sformatf("ffv[%0d]", d), 32'(ffv[d]), 32'(fv));
        chk($sformatf("ffi[%0d]", d), 32'(ffi[d]), fi);
        chk($sformatf("resp_vec[%0d]", d), resp[d], er);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int d);
    st[d] = 1'b1;
    cyc(1);
    st[d] = 1'b0;
  endtask

  initial begin
    st[0] = 1'b0; st[1] = 1'b0;
    mode[0] = 0; mode[1] = 0;
    cyc(2);
    chk("rst_dut_in", 32'(di[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_resp", resp[0], 0);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_busy", 32'(busy[0]), 0);
    // good cell, settle 2
    pulse(0);
    cyc(63);
    chk("good_done_early", 32'(done[0]), 0);
    cyc(1);
    chk("good_done", 32'(done[0]), 1);
    chk("good_pass", 32'(pass_o[0]), 1);
    chk("good_err", 32'(err[0]), 0);
    chk("good_ffv", 32'(ffv[0]), 0);
    chk("good_resp", resp[0], 32'h111F_FFFF);
    // ZN stuck at 1
    mode[0] = 1;
    pulse(0);
    cyc(64);
    chk("st1_err", 32'(err[0]), 9);
    chk("st1_ffi", 32'(ffi[0]), 21);
    chk("st1_pass", 32'(pass_o[0]), 0);
    chk("st1_resp", resp[0], 32'hFFFF_FFFF);
    // restart from failing DONE with a good cell
    mode[0] = 0;
    pulse(0);
    chk("restart_done", 32'(done[0]), 0);
    chk("restart_err", 32'(err[0]), 0);
    chk("restart_resp", resp[0], 0);
    cyc(64);
    chk("restart_pass", 32'(pass_o[0]), 1);
    chk("restart_ffv", 32'(ffv[0]), 0);
    // inverted cell
    mode[0] = 2;
    pulse(0);
    cyc(64);
    chk("inv_err", 32'(err[0]), 32);
    chk("inv_ffi", 32'(ffi[0]), 0);
    chk("inv_ffv", 32'(ffv[0]), 1);
    chk("inv_resp", resp[0], 32'hEEE0_0000);
    mode[0] = 0;
    // settle 1 with extra starts mid-sweep
    pulse(1);
    cyc(10);
    chk("s1_idx10", 32'(di[1]), 10);
    pulse(1);
    cyc(9);
    chk("s1_idx20", 32'(di[1]), 20);
    pulse(1);
    cyc(10);
    chk("s1_done_early", 32'(done[1]), 0);
    cyc(1);
    chk("s1_done", 32'(done[1]), 1);
    chk("s1_pass", 32'(pass_o[1]), 1);
    // reset mid-sweep at index 15
    pulse(0);
    cyc(30);
    chk("mid_idx15", 32'(di[0]), 15);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("mid_busy", 32'(busy[0]), 0);
    chk("mid_dut_in", 32'(di[0]), 0);
    chk("mid_err", 32'(err[0]), 0);
    chk("mid_resp", resp[0], 0);
    cyc(5);
    chk("mid_idle", 32'(busy[0]), 0);
    pulse(0);
    cyc(64);
    chk("post_pass", 32'(pass_o[0]), 1);
    chk("post_resp", resp[0], 32'h111F_FFFF);
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/oai221_sweep_checker.md
# oai221_sweep_checker

Self-checking stimulus/response stage for the OAI221_X1 cell. It drives all 32 input combinations onto the cell from a synchronous sequencer. After a programmable settle time it samples ZN for each combination and compares it against a parameterised truth table. It sits directly around the cell under test, upstream on A/B1/B2/C1/C2 and downstream on ZN, and gives the pass/fail result in hardware instead of through `$display` inspection.

## Interface
- SETTLE_CYCLES, 2, cycles each vector is held before ZN is sampled; legal range 1..255
- EXPECT, 32'h111F_FFFF, expected ZN per vector index; bit i is the expected ZN for index i (default = OAI221: ZN = !(A & (B1|B2) & (C1|C2)))
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  sweep request; sampled only in IDLE or DONE
- dut_in  out  5  {A,B1,B2,C1,C2} to the cell; bit 4 = A, bit 0 = C2; vector index = dut_in
- zn  in  1  ZN from the cell
- busy  out  1  high while a sweep is in progress
- done  out  1  sweep complete; sticky until next accepted start or reset
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  6  number of mismatching vectors, 0..32
- first_fail_vld  out  1  at least one mismatch recorded this sweep
- first_fail_idx  out  5  index of the first mismatching vector; 0 when first_fail_vld=0
- resp_vec  out  32  captured ZN; bit i = ZN sampled for index i

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst_n=0 at an edge): state IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vld=0, first_fail_idx=0, resp_vec=0, settle counter=0. Reset overrides start.
- IDLE to RUN on start=1. At the same edge: dut_in=0, settle counter=SETTLE_CYCLES-1, all result registers cleared, busy=1.
- In RUN, while the settle counter is nonzero it decrements each cycle and dut_in holds.
- In RUN, when the settle counter is 0, the edge samples zn:
  - resp_vec[idx] <= zn.
  - If zn != EXPECT[idx]: err_count increments. If first_fail_vld=0, then first_fail_vld=1 and first_fail_idx=idx.
  - If idx<31: dut_in=idx+1 and the counter reloads to SETTLE_CYCLES-1.
  - If idx==31: go to DONE with dut_in=0, busy=0, done=1. pass = (final err_count==0), including the index-31 compare.
- DONE to RUN on start=1, with the same actions as IDLE to RUN (done drops, results cleared). Without start, DONE holds and all results stay stable.
- start in RUN is ignored with no effect.
- The index never wraps in the middle of a sweep. The 5-bit index reaching 31 terminates the sweep. err_count saturates naturally at 32 and cannot overflow 6 bits.
- zn is compared as a registered 1-bit value. The cell output must be settled within SETTLE_CYCLES; this block adds no synchroniser.

## Timing
- Each vector is applied for exactly SETTLE_CYCLES cycles. zn is sampled at the last edge of that window, and dut_in advances at the same edge.
- If start is accepted at edge E:
  - vector i is driven from E+i·S to E+(i+1)·S, where S=SETTLE_CYCLES.
  - done=1 from edge E+32·S.
  - sweep length is 32·S cycles (64 at default).
- Results update at the sampling edge and are visible the following cycle. pass is valid in the same cycle done first reads 1.
- A reset asserted mid-sweep returns all outputs to reset values at that edge, and no partial result is retained. Deasserting reset does not start a sweep; start is required.

## Test plan
- Behavioural OAI221 model on zn, SETTLE_CYCLES=2, start pulse at edge E
  - -> dut_in steps 0..31 every 2 cycles; done at E+64; pass=1, err_count=0, first_fail_vld=0, resp_vec=32'h111F_FFFF.
- zn tied to 1
  - -> err_count=9, first_fail_idx=21, pass=0, resp_vec=32'hFFFF_FFFF.
- zn = inverted model output
  - -> err_count=32, first_fail_idx=0, resp_vec=32'hEEE0_0000.
- SETTLE_CYCLES=1; start pulses repeated at index 10 and index 20
  - -> sweep unaffected; done exactly 32 cycles after the first start.
- rst_n=0 for one cycle at index 15
  - -> next cycle busy=0, dut_in=0, err_count=0, resp_vec=0. No activity until the next start, after which a full 64-cycle sweep gives the model results.
- After a failing sweep (zn tied 1), start in DONE with the correct model
  - -> done drops on the start edge, results cleared, then pass=1 with first_fail_vld=0.
